// File: rtl/registers.sv
// registers: 32 x 32-bit register file, two read ports (combinational + clocked), one write port, reg 0 reads zero
module registers #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 2**ADDR_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addra,
  output logic [DATA_WIDTH-1:0] dataa,
  output logic [DATA_WIDTH-1:0] ass_dataa,
  input  logic [ADDR_WIDTH-1:0] addrb,
  output logic [DATA_WIDTH-1:0] datab,
  output logic [DATA_WIDTH-1:0] ass_datab,
  input  logic                  enc,
  input  logic [ADDR_WIDTH-1:0] addrc,
  input  logic [DATA_WIDTH-1:0] datac
);
  logic [DATA_WIDTH-1:0] mem [0:NUM_REGS-1];
  logic                  wr;
  // a write only lands when enabled and aimed at a non-zero register
  always_comb begin
    wr        = enc && (addrc != '0);
    ass_dataa = (addra == '0) ? '0 : mem[addra];
    ass_datab = (addrb == '0) ? '0 : mem[addrb];
  end
  // register storage; entry 0 is never written so it stays at its reset value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[addrc] <= datac;
    end
  end
  // clocked reads with write-first bypass when the write targets the read address
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dataa <= '0;
      datab <= '0;
    end else begin
      dataa <= (wr && addrc == addra) ? datac : ass_dataa;
      datab <= (wr && addrc == addrb) ? datac : ass_datab;
    end
  end
endmodule

// File: tb/tb_registers.sv
// tb_registers: directed bench for the register file with a behavioural model and per-cycle compare
module tb_registers;
  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  addra, addrb, addrc;
  logic [31:0] dataa, datab, ass_dataa, ass_datab, datac;
  logic        enc;
  logic [31:0] m [0:31];
  logic [31:0] ea, eb;
  logic        cmp_on = 1'b0;
  int          checks = 0;
  int          errors = 0;

  registers dut (
    .clock(clock), .reset(reset),
    .addra(addra), .dataa(dataa), .ass_dataa(ass_dataa),
    .addrb(addrb), .datab(datab), .ass_datab(ass_datab),
    .enc(enc), .addrc(addrc), .datac(datac)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  // model: architectural state after each edge; clocked outputs show the post-edge register contents
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) m[i] = 32'h0;
      ea = 32'h0;
      eb = 32'h0;
    end else begin
      if (enc && addrc != 5'd0) m[addrc] = datac;
      ea = m[addra];
      eb = m[addrb];
    end
  end

  // compare all four outputs against the model every cycle
  always @(negedge clock) begin
    if (cmp_on) begin
      chk("cyc_dataa", dataa, ea);
      chk("cyc_datab", datab, eb);
      chk("cyc_ass_dataa", ass_dataa, m[addra]);
      chk("cyc_ass_datab", ass_datab, m[addrb]);
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    ea = 32'h0;
    eb = 32'h0;
    reset = 1'b0;
    enc = 1'b0;
    addra = 5'd0;
    addrb = 5'd0;
    addrc = 5'd0;
    datac = 32'h0;
    #1;
    cmp_on = 1'b1;
    for (int i = 0; i < 32; i++) begin
      enc = 1'b1;
      addrc = 5'(i);
      datac = 32'hCAFE0000 + 32'(i);
      addra = 5'(i);
      addrb = 5'(31 - i);
      step();
      chk("rst_ass_dataa", ass_dataa, 32'h0);
      chk("rst_dataa", dataa, 32'h0);
    end
    reset = 1'b1;
    enc = 1'b0;
    for (int i = 0; i < 32; i++) begin
      addrc = 5'(i);
      datac = 32'hDEADBEEF;
      addra = 5'(i);
      addrb = 5'(i);
      step();
    end
    for (int i = 0; i < 32; i++) begin
      addra = 5'(i);
      #1;
      chk("noen_ass_dataa", ass_dataa, 32'h0);
      chk("noen_dataa", dataa, 32'h0);
    end
    enc = 1'b1;
    addrc = 5'd5;
    datac = 32'h12345678;
    addra = 5'd0;
    addrb = 5'd0;
    #1;
    chk("nobypass_ass_dataa", ass_dataa, 32'h0);
    step();
    enc = 1'b0;
    addra = 5'd5;
    #1;
    chk("wr5_ass_dataa", ass_dataa, 32'h12345678);
    chk("wr5_dataa_before", dataa, 32'h0);
    step();
    chk("wr5_dataa_after", dataa, 32'h12345678);
    enc = 1'b1;
    addrc = 5'd0;
    datac = 32'hFFFFFFFF;
    addra = 5'd0;
    addrb = 5'd5;
    step();
    chk("wr0_ass_dataa", ass_dataa, 32'h0);
    chk("wr0_dataa", dataa, 32'h0);
    enc = 1'b0;
    step();
    chk("wr0_dataa_late", dataa, 32'h0);
    chk("wr0_datab", datab, 32'h12345678);
    enc = 1'b1;
    addra = 5'd7;
    addrb = 5'd7;
    addrc = 5'd7;
    datac = 32'hA5A5A5A5;
    step();
    chk("coll_dataa", dataa, 32'hA5A5A5A5);
    chk("coll_datab", datab, 32'hA5A5A5A5);
    chk("coll_ass_datab", ass_datab, 32'hA5A5A5A5);
    for (int i = 1; i < 32; i++) begin
      enc = 1'b1;
      addrc = 5'(i);
      datac = $urandom;
      addra = 5'(i);
      addrb = 5'($urandom_range(0, 31));
      step();
    end
    enc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      addra = 5'($urandom_range(0, 31));
      addrb = 5'($urandom_range(0, 31));
      step();
    end
    addra = 5'd9;
    addrb = 5'd9;
    step();
    reset = 1'b0;
    #1;
    chk("async_dataa", dataa, 32'h0);
    chk("async_datab", datab, 32'h0);
    chk("async_ass_dataa", ass_dataa, 32'h0);
    chk("async_ass_datab", ass_datab, 32'h0);
    step();
    reset = 1'b1;
    enc = 1'b1;
    addrc = 5'd3;
    datac = 32'h0BADF00D;
    addra = 5'd3;
    addrb = 5'd9;
    step();
    chk("resume_dataa", dataa, 32'h0BADF00D);
    chk("resume_datab", datab, 32'h0);
    enc = 1'b0;
    step();
    step();
    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
